// File: rtl/ecc_dec_sink.sv
// Receive stage behind the SECDED decoder. Decoded words go into a small
// FIFO with a valid/ready output. Words flagged as double-bit errors can be
// discarded. The block also keeps saturating error counters, captures the
// syndrome of the first error and raises a db-error threshold alarm.
module ecc_dec_sink #(
    parameter int K         = 4,
    parameter int M         = 3,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    parameter int DB_THRESH = 1,
    parameter int DROP_DB   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [K-1:0]     q_i,
    input  logic [M:0]       syndrome_i,
    input  logic             sb_err_i,
    input  logic             db_err_i,
    output logic             ready_o,
    output logic             m_valid_o,
    output logic [K-1:0]     m_data_o,
    output logic             m_err_o,
    input  logic             m_ready_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic             err_vld_o,
    output logic [M:0]       err_syn_o,
    output logic             alarm_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        ALARM
    } alarm_state_e;

    // FIFO storage and bookkeeping
    logic [K:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Link-health state
    logic [CNT_W-1:0] r_sb_cnt;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_err_vld;
    logic [M:0]       r_err_syn;
    logic             r_ovf;
    alarm_state_e     r_state;
    alarm_state_e     w_state_nxt;

    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    logic [K:0]       w_head;
    logic             w_sb_evt;
    logic             w_db_evt;
    logic [CNT_W-1:0] w_sb_nxt;
    logic [CNT_W-1:0] w_db_nxt;
    logic             w_capture;
    logic             w_ovf_set;

    // full/ready come only from registered occupancy, never from m_ready_i,
    // so a pop in the same cycle does not open room for a push.
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_drop   = (DROP_DB != 0) && db_err_i;
    assign w_push   = valid_i && !w_full && !w_drop;
    assign w_pop    = !w_empty && m_ready_i;
    assign w_head   = r_mem[r_rd_ptr];

    assign ready_o   = !w_full;
    assign m_valid_o = !w_empty;
    assign m_data_o  = w_empty ? '0 : w_head[K-1:0];
    assign m_err_o   = !w_empty && w_head[K];

    // An illegal sb+db combination counts as db only.
    assign w_db_evt  = valid_i && db_err_i;
    assign w_sb_evt  = valid_i && sb_err_i && !db_err_i;
    assign w_sb_nxt  = (w_sb_evt && (r_sb_cnt != '1)) ? r_sb_cnt + CNT_W'(1) : r_sb_cnt;
    assign w_db_nxt  = (w_db_evt && (r_db_cnt != '1)) ? r_db_cnt + CNT_W'(1) : r_db_cnt;
    assign w_capture = valid_i && (sb_err_i || db_err_i) && !r_err_vld;
    // A lost word is one that would have been pushed but for a full FIFO.
    assign w_ovf_set = valid_i && w_full && !w_drop;

    // Storage write on push
    // NOTE: the data array has no reset; reads are masked while empty, so its contents never leak.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {db_err_i, q_i};
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counters, first-error capture and overflow flag; clear beats any event
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_sb_cnt  <= '0;
            r_db_cnt  <= '0;
            r_err_vld <= 1'b0;
            r_err_syn <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_sb_cnt <= w_sb_nxt;
            r_db_cnt <= w_db_nxt;
            if (w_capture) begin
                r_err_vld <= 1'b1;
                r_err_syn <= syndrome_i;
            end
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    // Alarm state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Alarm next state: look at the next db count so the alarm rises together with it
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        if (clr_i) begin
            w_state_nxt = IDLE;
        end else if ((r_state == IDLE) && (w_db_nxt >= CNT_W'(DB_THRESH))) begin
            w_state_nxt = ALARM;
        end
    end

    assign sb_cnt_o  = r_sb_cnt;
    assign db_cnt_o  = r_db_cnt;
    assign err_vld_o = r_err_vld;
    assign err_syn_o = r_err_syn;
    assign ovf_o     = r_ovf;
    assign alarm_o   = (r_state == ALARM);

endmodule

// File: tb/tb_ecc_dec_sink.sv
// Bench for ecc_dec_sink. Two instances share the stimulus: A drops db words
// (CNT_W=2, threshold 2), B keeps them with the err flag (CNT_W=3, threshold 3).
// A queue-based model of each instance is compared after every clock edge;
// a hand-derived vector table and a short db/alarm sequence pin down the
// corner cases, followed by a long randomized run.
module tb_ecc_dec_sink;

    localparam int K = 4;
    localparam int M = 3;
    localparam int DEPTH = 4;
    localparam int P_CMAX [2] = '{3, 7};
    localparam int P_THR  [2] = '{2, 3};
    localparam bit P_DROP [2] = '{1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst, valid, sb, db, m_ready, clr;
    logic [K-1:0] q;
    logic [M:0]   syn;

    logic a_rdy, a_mv, a_merr, a_ev, a_al, a_ovf;
    logic [K-1:0] a_md;
    logic [1:0]   a_sbc, a_dbc;
    logic [M:0]   a_syn;
    logic b_rdy, b_mv, b_merr, b_ev, b_al, b_ovf;
    logic [K-1:0] b_md;
    logic [2:0]   b_sbc, b_dbc;
    logic [M:0]   b_syn;

    always #5 clk = ~clk;

    ecc_dec_sink #(.K(K), .M(M), .DEPTH(DEPTH), .CNT_W(2), .DB_THRESH(2), .DROP_DB(1)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .q_i(q), .syndrome_i(syn),
        .sb_err_i(sb), .db_err_i(db), .ready_o(a_rdy), .m_valid_o(a_mv),
        .m_data_o(a_md), .m_err_o(a_merr), .m_ready_i(m_ready), .clr_i(clr),
        .sb_cnt_o(a_sbc), .db_cnt_o(a_dbc), .err_vld_o(a_ev), .err_syn_o(a_syn),
        .alarm_o(a_al), .ovf_o(a_ovf)
    );

    ecc_dec_sink #(.K(K), .M(M), .DEPTH(DEPTH), .CNT_W(3), .DB_THRESH(3), .DROP_DB(0)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .q_i(q), .syndrome_i(syn),
        .sb_err_i(sb), .db_err_i(db), .ready_o(b_rdy), .m_valid_o(b_mv),
        .m_data_o(b_md), .m_err_o(b_merr), .m_ready_i(m_ready), .clr_i(clr),
        .sb_cnt_o(b_sbc), .db_cnt_o(b_dbc), .err_vld_o(b_ev), .err_syn_o(b_syn),
        .alarm_o(b_al), .ovf_o(b_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state, one slot per instance
    logic [K:0]   mq [2][$];
    int           m_sb [2];
    int           m_db [2];
    bit           m_ev [2];
    bit           m_al [2];
    bit           m_ovf [2];
    logic [M:0]   m_syn [2];

    typedef struct {
        logic rst, v, sb, db, mr, clr;
        logic [K-1:0] q;
        logic [M:0]   syn;
        logic ex_mv, ex_rdy, ex_al, ex_ovf, ex_ev;
        logic [K-1:0] ex_md;
        logic [M:0]   ex_syn;
        int ex_sb, ex_db;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        bit full, drop, push, pop;
        if (rst) begin
            mq[i].delete();
            m_sb[i] = 0; m_db[i] = 0; m_ev[i] = 0; m_al[i] = 0; m_ovf[i] = 0; m_syn[i] = '0;
        end else begin
            full = (mq[i].size() == DEPTH);
            drop = P_DROP[i] && db;
            pop  = (mq[i].size() > 0) && m_ready;
            push = valid && !full && !drop;
            if (pop)  void'(mq[i].pop_front());
            if (push) mq[i].push_back({db, q});
            if (clr) begin
                m_sb[i] = 0; m_db[i] = 0; m_ev[i] = 0; m_al[i] = 0; m_ovf[i] = 0; m_syn[i] = '0;
            end else begin
                if (valid) begin
                    if (db)      m_db[i] = (m_db[i] < P_CMAX[i]) ? m_db[i] + 1 : m_db[i];
                    else if (sb) m_sb[i] = (m_sb[i] < P_CMAX[i]) ? m_sb[i] + 1 : m_sb[i];
                    if ((sb || db) && !m_ev[i]) begin
                        m_ev[i] = 1; m_syn[i] = syn;
                    end
                    if (full && !drop) m_ovf[i] = 1;
                end
                if (m_db[i] >= P_THR[i]) m_al[i] = 1;
            end
        end
    endtask

    task automatic check_model(input int i, input string p, input int mv, input int md,
                               input int merr, input int rdy, input int sbc, input int dbc,
                               input int al, input int ovf, input int ev, input int sy);
        logic [K:0] head;
        head = (mq[i].size() > 0) ? mq[i][0] : '0;
        check({p, ".m_valid"}, mv, int'(mq[i].size() > 0));
        check({p, ".m_data"}, md, int'(head[K-1:0]));
        check({p, ".m_err"}, merr, int'(head[K]));
        check({p, ".ready"}, rdy, int'(mq[i].size() < DEPTH));
        check({p, ".sb_cnt"}, sbc, m_sb[i]);
        check({p, ".db_cnt"}, dbc, m_db[i]);
        check({p, ".alarm"}, al, int'(m_al[i]));
        check({p, ".ovf"}, ovf, int'(m_ovf[i]));
        check({p, ".err_vld"}, ev, int'(m_ev[i]));
        check({p, ".err_syn"}, sy, int'(m_syn[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cyc++;
        check_model(0, "A", a_mv, a_md, a_merr, a_rdy, a_sbc, a_dbc, a_al, a_ovf, a_ev, a_syn);
        check_model(1, "B", b_mv, b_md, b_merr, b_rdy, b_sbc, b_dbc, b_al, b_ovf, b_ev, b_syn);
    endtask

    task automatic add(input logic r, input logic v, input logic [K-1:0] qq, input logic [M:0] sy,
                       input logic s, input logic d, input logic mr, input logic c,
                       input logic emv, input logic [K-1:0] emd, input logic erdy,
                       input int esb, input int edb, input logic eal, input logic eovf,
                       input logic eev, input logic [M:0] esyn);
        vec_t t;
        t.rst = r; t.v = v; t.q = qq; t.syn = sy; t.sb = s; t.db = d; t.mr = mr; t.clr = c;
        t.ex_mv = emv; t.ex_md = emd; t.ex_rdy = erdy; t.ex_sb = esb; t.ex_db = edb;
        t.ex_al = eal; t.ex_ovf = eovf; t.ex_ev = eev; t.ex_syn = esyn;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic [K-1:0] qq, input logic [M:0] sy,
                         input logic s, input logic d, input logic mr, input logic c);
        rst = r; valid = v; q = qq; syn = sy; sb = s; db = d; m_ready = mr; clr = c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expectations for instance A (drop db, 2-bit counters, threshold 2)
        //   rst v  q     syn   sb db mr clr | mv md   rdy sb db al ovf ev syn
        // in-order delivery with m_ready high
        add(0, 1, 4'h1, 4'h0, 0, 0, 1, 0,   1, 4'h1, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 4'h2, 4'h0, 0, 0, 1, 0,   1, 4'h2, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 4'h3, 4'h0, 0, 0, 1, 0,   1, 4'h3, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
        // fill to full, overflow, then push+pop while full
        add(0, 1, 4'h4, 4'h0, 0, 0, 0, 0,   1, 4'h4, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 4'h5, 4'h0, 0, 0, 0, 0,   1, 4'h4, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 4'h6, 4'h0, 0, 0, 0, 0,   1, 4'h4, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 4'h7, 4'h0, 0, 0, 0, 0,   1, 4'h4, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 4'h8, 4'h0, 0, 0, 0, 0,   1, 4'h4, 0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 1, 4'h9, 4'h0, 0, 0, 1, 0,   1, 4'h5, 1, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   1, 4'h6, 1, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   1, 4'h7, 1, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   0, 4'h0, 1, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 1,   0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
        // single-bit errors: first syndrome kept
        add(0, 1, 4'hA, 4'h7, 1, 0, 0, 0,   1, 4'hA, 1, 1, 0, 0, 0, 1, 4'h7);
        add(0, 1, 4'hB, 4'h3, 1, 0, 0, 0,   1, 4'hA, 1, 2, 0, 0, 0, 1, 4'h7);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   1, 4'hB, 1, 2, 0, 0, 0, 1, 4'h7);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   0, 4'h0, 1, 2, 0, 0, 0, 1, 4'h7);
        // dropped db words and the alarm rising with the count
        add(0, 1, 4'hC, 4'h8, 0, 1, 1, 0,   0, 4'h0, 1, 2, 1, 0, 0, 1, 4'h7);
        add(0, 1, 4'hD, 4'h9, 0, 1, 1, 0,   0, 4'h0, 1, 2, 2, 1, 0, 1, 4'h7);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 1,   0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
        // sb counter saturation, then clear beats a same-cycle sb event
        add(0, 1, 4'h1, 4'h1, 1, 0, 1, 0,   1, 4'h1, 1, 1, 0, 0, 0, 1, 4'h1);
        add(0, 1, 4'h2, 4'h1, 1, 0, 1, 0,   1, 4'h2, 1, 2, 0, 0, 0, 1, 4'h1);
        add(0, 1, 4'h3, 4'h1, 1, 0, 1, 0,   1, 4'h3, 1, 3, 0, 0, 0, 1, 4'h1);
        add(0, 1, 4'h4, 4'h1, 1, 0, 1, 0,   1, 4'h4, 1, 3, 0, 0, 0, 1, 4'h1);
        add(0, 1, 4'h5, 4'h1, 1, 0, 1, 0,   1, 4'h5, 1, 3, 0, 0, 0, 1, 4'h1);
        add(0, 1, 4'hE, 4'h2, 1, 0, 1, 1,   1, 4'hE, 1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 0, 4'h0, 4'h0, 0, 0, 1, 0,   0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
        // buffer words, overflow, then reset mid-stream
        add(0, 1, 4'h1, 4'h4, 1, 0, 0, 0,   1, 4'h1, 1, 1, 0, 0, 0, 1, 4'h4);
        add(0, 1, 4'h2, 4'h0, 0, 0, 0, 0,   1, 4'h1, 1, 1, 0, 0, 0, 1, 4'h4);
        add(0, 1, 4'h3, 4'h0, 0, 0, 0, 0,   1, 4'h1, 1, 1, 0, 0, 0, 1, 4'h4);
        add(0, 1, 4'h4, 4'h0, 0, 0, 0, 0,   1, 4'h1, 0, 1, 0, 0, 0, 1, 4'h4);
        add(0, 1, 4'h5, 4'h0, 0, 0, 0, 0,   1, 4'h1, 0, 1, 0, 0, 1, 1, 4'h4);
        add(1, 1, 4'h6, 4'h5, 1, 0, 1, 0,   0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);

        // Reset
        drive(1, 0, '0, '0, 0, 0, 0, 0);
        step();
        step();
        check("reset.ready", a_rdy, 1);
        check("reset.m_valid", a_mv, 0);
        check("reset.m_data", a_md, 0);
        check("reset.m_err", b_merr, 0);
        check("reset.alarm", a_al, 0);

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].q, vecs[i].syn, vecs[i].sb, vecs[i].db,
                  vecs[i].mr, vecs[i].clr);
            step();
            check($sformatf("row%0d.m_valid", i), a_mv, vecs[i].ex_mv);
            check($sformatf("row%0d.m_data", i), a_md, vecs[i].ex_md);
            check($sformatf("row%0d.ready", i), a_rdy, vecs[i].ex_rdy);
            check($sformatf("row%0d.sb_cnt", i), a_sbc, vecs[i].ex_sb);
            check($sformatf("row%0d.db_cnt", i), a_dbc, vecs[i].ex_db);
            check($sformatf("row%0d.alarm", i), a_al, vecs[i].ex_al);
            check($sformatf("row%0d.ovf", i), a_ovf, vecs[i].ex_ovf);
            check($sformatf("row%0d.err_vld", i), a_ev, vecs[i].ex_ev);
            check($sformatf("row%0d.err_syn", i), a_syn, vecs[i].ex_syn);
        end

        // db words into B (kept, flagged) vs A (dropped); thresholds 2 and 3
        drive(0, 1, 4'h3, 4'h5, 0, 1, 1, 0);
        step();
        check("db1.a_db", a_dbc, 1);
        check("db1.a_m_valid", a_mv, 0);
        check("db1.b_m_valid", b_mv, 1);
        check("db1.b_m_err", b_merr, 1);
        check("db1.b_m_data", b_md, 3);
        check("db1.a_err_syn", a_syn, 5);
        drive(0, 1, 4'h4, 4'h6, 0, 1, 1, 0);
        step();
        check("db2.a_alarm", a_al, 1);
        check("db2.b_alarm", b_al, 0);
        drive(0, 1, 4'h5, 4'h6, 1, 1, 1, 0);
        step();
        check("db3.b_db", b_dbc, 3);
        check("db3.b_alarm", b_al, 1);
        check("db3.b_sb_illegal", b_sbc, 0);
        drive(0, 1, 4'h6, 4'h6, 0, 1, 1, 0);
        step();
        check("db4.a_db_sat", a_dbc, 3);
        check("db4.b_db", b_dbc, 4);
        drive(0, 1, 4'h7, 4'h6, 0, 1, 1, 1);
        step();
        check("dbclr.a_db", a_dbc, 0);
        check("dbclr.b_alarm", b_al, 0);
        check("dbclr.b_m_data", b_md, 7);

        // Randomized run against the model, alternating drain-heavy and fill-heavy phases
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 7);
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  K'($urandom),
                  (M+1)'($urandom),
                  (r == 1) || (r == 2) || (r == 7),
                  (r == 3) || (r == 7),
                  ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 39) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
